// File: rtl/alu_muldiv_if.sv
// Start/operand/result bundle for the alu_muldiv multi-cycle multiply/divide unit.
interface alu_muldiv_if #(parameter int WIDTH = 8);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;
  logic             ov_o;
  logic             cy_o;
  logic             busy;
  logic             done;

  modport master (
    output start, op, a, b,
    input  result_lo, result_hi, ov_o, cy_o, busy, done
  );

  modport slave (
    input  start, op, a, b,
    output result_lo, result_hi, ov_o, cy_o, busy, done
  );
endinterface

// File: rtl/alu_muldiv.sv
// Iterative shift-add multiply / restoring divide, one bit per clock.
// Define ALU_MULDIV_SIGNED_EN to enable signed ops (op 2/3); otherwise op[1] is ignored.
//
// state | meaning
// IDLE  | waiting for start; operands captured on accept
// RUN   | one multiply/divide iteration per clock, WIDTH iterations
// DONE  | one-cycle done pulse; result registers already loaded
module alu_muldiv #(
  parameter int WIDTH = 8
) (
  input logic         clk,
  input logic         rst_n,
  alu_muldiv_if.slave bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      count;
  logic [2*WIDTH:0]   acc, acc_nxt;
  logic [WIDTH-1:0]   bw;
  logic               is_div;
  logic [WIDTH-1:0]   res_lo_q, res_hi_q;
  logic               ov_q, cy_q;

  logic               accept, div_zero, last;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH:0]   sh;
  logic [WIDTH+1:0]   diff;
  logic [2*WIDTH-1:0] mul_p;
  logic [WIDTH-1:0]   quo, rem;
  logic [WIDTH-1:0]   fin_lo, fin_hi;
  logic               fin_ov;

  assign accept   = (state == IDLE) && bus.start;
  assign div_zero = bus.op[0] && (bus.b == '0);
  assign last     = (count == CW'(WIDTH - 1));

`ifdef ALU_MULDIV_SIGNED_EN
  logic is_sgn, neg_lo, neg_hi;
  logic a_neg, b_neg;

  always_comb begin
    a_neg = bus.op[1] & bus.a[WIDTH-1];
    b_neg = bus.op[1] & bus.b[WIDTH-1];
    a_mag = a_neg ? (~bus.a + 1'b1) : bus.a;
    b_mag = b_neg ? (~bus.b + 1'b1) : bus.b;
  end
`else
  logic unused_op_hi;
  assign unused_op_hi = bus.op[1];
  assign a_mag = bus.a;
  assign b_mag = bus.b;
`endif

  // acc = {partial (W+1), low word}: low word shifts out multiplier bits or in quotient bits
  always_comb begin
    sum  = acc[2*WIDTH:WIDTH] + {1'b0, bw};
    sh   = {acc[2*WIDTH-1:0], 1'b0};
    diff = {1'b0, sh[2*WIDTH:WIDTH]} - {2'b00, bw};
    if (is_div)
      acc_nxt = diff[WIDTH+1] ? sh : {diff[WIDTH:0], sh[WIDTH-1:1], 1'b1};
    else
      acc_nxt = {(acc[0] ? sum : acc[2*WIDTH:WIDTH]), acc[WIDTH-1:0]} >> 1;
  end

  always_comb begin
    mul_p = acc_nxt[2*WIDTH-1:0];
    quo   = acc_nxt[WIDTH-1:0];
    rem   = acc_nxt[2*WIDTH-1:WIDTH];
`ifdef ALU_MULDIV_SIGNED_EN
    if (neg_lo) begin
      mul_p = ~mul_p + 1'b1;
      quo   = ~quo + 1'b1;
    end
    if (neg_hi) rem = ~rem + 1'b1;
`endif
    if (is_div) begin
      fin_lo = quo;
      fin_hi = rem;
      fin_ov = 1'b0;
    end else begin
      fin_lo = mul_p[WIDTH-1:0];
      fin_hi = mul_p[2*WIDTH-1:WIDTH];
      fin_ov = (fin_hi != '0);
`ifdef ALU_MULDIV_SIGNED_EN
      if (is_sgn) fin_ov = (fin_hi != {WIDTH{fin_lo[WIDTH-1]}});
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start) state_nxt = div_zero ? DONE : RUN;
      RUN:  if (last) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      acc      <= '0;
      bw       <= '0;
      is_div   <= 1'b0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      ov_q     <= 1'b0;
      cy_q     <= 1'b0;
`ifdef ALU_MULDIV_SIGNED_EN
      is_sgn   <= 1'b0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
`endif
    end else if (accept) begin
      count  <= '0;
      acc    <= {{(WIDTH+1){1'b0}}, a_mag};
      bw     <= b_mag;
      is_div <= bus.op[0];
`ifdef ALU_MULDIV_SIGNED_EN
      is_sgn <= bus.op[1];
      neg_lo <= a_neg ^ b_neg;
      neg_hi <= a_neg;
`endif
      // Divide by zero bypasses RUN, so its result is loaded straight from the inputs
      if (div_zero) begin
        res_lo_q <= '1;
        res_hi_q <= bus.a;
        ov_q     <= 1'b1;
        cy_q     <= 1'b0;
      end
    end else if (state == RUN) begin
      acc   <= acc_nxt;
      count <= count + 1'b1;
      if (last) begin
        res_lo_q <= fin_lo;
        res_hi_q <= fin_hi;
        ov_q     <= fin_ov;
        cy_q     <= 1'b0;
      end
    end
  end

  assign bus.result_lo = res_lo_q;
  assign bus.result_hi = res_hi_q;
  assign bus.ov_o      = ov_q;
  assign bus.cy_o      = cy_q;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);
endmodule
